// File: rtl/aq_mem_pkg.sv
// Shared types for the memory-side blocks: grant encoding and default starvation bound.
package aq_mem_pkg;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_CPU  = 2'd1,
    G_LD   = 2'd2,
    G_TP   = 2'd3
  } grant_t;

  localparam int MAXWAIT_DEF = 8;

  function automatic logic grant_is_bg(input grant_t g);
    return (g == G_LD) || (g == G_TP);
  endfunction

endpackage

// File: rtl/ram_arb_starve.sv
// Background starvation guard: counts CPU-blocked cycles and forces a one-cycle CPU hold.
module ram_arb_starve
  import aq_mem_pkg::*;
#(
  parameter int MAXWAIT = MAXWAIT_DEF
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic bg_pending,
  input  logic bg_granted,
  input  logic cpu_sel,
  output logic cpu_hold
);

  localparam logic [7:0] WLAST = 8'(MAXWAIT - 1);

  logic [7:0] wcnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wcnt     <= 8'd0;
      cpu_hold <= 1'b0;
    end else if (cpu_sel && cpu_hold) begin
      // CPU ignored the hold: keep holding, freeze the count
      cpu_hold <= 1'b1;
    end else if (bg_granted || !bg_pending) begin
      wcnt     <= 8'd0;
      cpu_hold <= 1'b0;
    end else if (wcnt == WLAST) begin
      wcnt     <= 8'd0;
      cpu_hold <= 1'b1;
    end else begin
      wcnt     <= wcnt + 8'd1;
      cpu_hold <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// One single-port RAM shared by CPU, loader (write) and tape (read); fixed priority CPU > loader > tape.
// last_grant | meaning: G_NONE idle | G_CPU ram_q -> cpu_dout | G_LD write, nothing to route | G_TP ram_q -> tp_dout, tp_ack
module ram_arbiter
  import aq_mem_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int MAXWAIT = MAXWAIT_DEF
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          cpu_sel,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_hold,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_din,
  output logic          ld_ack,
  input  logic          tp_req,
  input  logic [AW-1:0] tp_addr,
  output logic [DW-1:0] tp_dout,
  output logic          tp_ack,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_q
);

  grant_t        grant;
  grant_t        last_grant;
  logic          tp_elig;
  logic [DW-1:0] cpu_dout_q;
  logic [DW-1:0] tp_dout_q;

  assign tp_elig = tp_req && !tp_ack;

  always_comb begin
    grant = G_NONE;
    if (!reset) begin
      if (cpu_sel)      grant = G_CPU;
      else if (ld_req)  grant = G_LD;
      else if (tp_elig) grant = G_TP;
    end
  end

  always_comb begin
    ram_en   = (grant != G_NONE);
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    case (grant)
      G_CPU: begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = cpu_we;
      end
      G_LD: begin
        ram_addr = ld_addr;
        ram_din  = ld_din;
        ram_we   = 1'b1;
      end
      G_TP: begin
        ram_addr = tp_addr;
      end
      default: ;
    endcase
  end

  assign ld_ack = (grant == G_LD);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      last_grant <= G_NONE;
      tp_ack     <= 1'b0;
      cpu_dout_q <= '0;
      tp_dout_q  <= '0;
    end else begin
      last_grant <= grant;
      tp_ack     <= (grant == G_TP);
      if (last_grant == G_CPU) cpu_dout_q <= ram_q;
      if (last_grant == G_TP)  tp_dout_q  <= ram_q;
    end
  end

  // RAM output is already a register; pass it through in the routed cycle, hold it afterwards
  assign cpu_dout = (last_grant == G_CPU) ? ram_q : cpu_dout_q;
  assign tp_dout  = (last_grant == G_TP)  ? ram_q : tp_dout_q;

  ram_arb_starve #(
    .MAXWAIT(MAXWAIT)
  ) u_starve (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .bg_pending(ld_req || tp_elig),
    .bg_granted(grant_is_bg(grant)),
    .cpu_sel   (cpu_sel),
    .cpu_hold  (cpu_hold)
  );

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios with literal expectations, then random traffic against a behavioural model.
module tb_ram_arbiter;

  localparam int MW = 8;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        cpu_sel = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_hold;
  logic        ld_req = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [7:0]  ld_din = '0;
  logic        ld_ack;
  logic        tp_req = 1'b0;
  logic [15:0] tp_addr = '0;
  logic [7:0]  tp_dout;
  logic        tp_ack;
  logic        ram_en, ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_q = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  ram_arbiter #(.AW(16), .DW(8), .MAXWAIT(MW)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .cpu_sel (cpu_sel),
    .cpu_we  (cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_din (cpu_din),
    .cpu_dout(cpu_dout),
    .cpu_hold(cpu_hold),
    .ld_req  (ld_req),
    .ld_addr (ld_addr),
    .ld_din  (ld_din),
    .ld_ack  (ld_ack),
    .tp_req  (tp_req),
    .tp_addr (tp_addr),
    .tp_dout (tp_dout),
    .tp_ack  (tp_ack),
    .ram_en  (ram_en),
    .ram_we  (ram_we),
    .ram_addr(ram_addr),
    .ram_din (ram_din),
    .ram_q   (ram_q)
  );

  // Physical RAM: read-before-write, q updates on every enabled cycle
  logic [7:0] ram_mem [0:65535];
  always @(posedge clk_sys) begin
    if (ram_en) begin
      ram_q <= ram_mem[ram_addr];
      if (ram_we) ram_mem[ram_addr] <= ram_din;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who gets the RAM, what the reads return, when the hold must fire
  logic [7:0] ref_mem [0:65535];
  bit         mvalid = 1'b0;
  bit         m_hold, m_ack;
  int         m_blocked;
  logic [7:0] m_cpu_q, m_tp_q;

  always @(negedge clk_sys) begin
    int          who;
    logic [15:0] a;
    logic [7:0]  d;
    logic        we;
    logic        bg_wait;
    who = 0;
    if (!reset) begin
      if (cpu_sel)                 who = 1;
      else if (ld_req)             who = 2;
      else if (tp_req && !m_ack)   who = 3;
    end
    a = '0; d = '0; we = 1'b0;
    if (who == 1) begin a = cpu_addr; d = cpu_din; we = cpu_we; end
    if (who == 2) begin a = ld_addr;  d = ld_din;  we = 1'b1;   end
    if (who == 3) begin a = tp_addr; end
    bg_wait = (who == 1) && (ld_req || (tp_req && !m_ack));
    if (mvalid) begin
      check("ram_en", ram_en, who != 0);
      check("ram_we", ram_we, we);
      check("ld_ack", ld_ack, who == 2);
      if (who != 0) check("ram_addr", ram_addr, a);
      if (we) check("ram_din", ram_din, d);
      check("cpu_hold", cpu_hold, m_hold);
      check("tp_ack", tp_ack, m_ack);
      check("cpu_dout", cpu_dout, m_cpu_q);
      check("tp_dout", tp_dout, m_tp_q);
    end
    if (reset) begin
      mvalid = 1'b1; m_hold = 1'b0; m_ack = 1'b0; m_blocked = 0;
      m_cpu_q = '0; m_tp_q = '0;
    end else if (mvalid) begin
      if (who == 1) m_cpu_q = ref_mem[a];
      if (who == 3) m_tp_q  = ref_mem[a];
      if (we) ref_mem[a] = d;
      m_ack = (who == 3);
      if (cpu_sel && m_hold) begin
        m_hold = 1'b1;
      end else if (bg_wait) begin
        m_blocked++;
        m_hold = (m_blocked == MW);
        if (m_hold) m_blocked = 0;
      end else begin
        m_blocked = 0;
        m_hold = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic quiet();
    cpu_sel = 1'b0; cpu_we = 1'b0; ld_req = 1'b0; tp_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_cnt;
    int acks;
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = 8'(i * 37 + 5);
      ref_mem[i] = 8'(i * 37 + 5);
    end

    // Reset then idle
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk_sys);
      check("idle_ram_en", ram_en, 1'b0);
    end
    check("idle_cpu_dout", cpu_dout, 8'h00);
    check("idle_tp_dout", tp_dout, 8'h00);
    check("idle_tp_ack", tp_ack, 1'b0);
    check("idle_cpu_hold", cpu_hold, 1'b0);

    // CPU write then read back
    tick();
    cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3800; cpu_din = 8'h5A;
    tick();
    cpu_we = 1'b0;
    tick();
    quiet();
    @(negedge clk_sys);
    check("cpu_readback", cpu_dout, 8'h5A);

    // Loader burst, then tape read of one loaded byte
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ld_req = 1'b1; ld_addr = 16'hC000 + 16'(i); ld_din = 8'(8'h11 * (i + 1));
      @(negedge clk_sys);
      if (ld_ack) acks++;
    end
    check("ld_burst_acks", acks, 4);
    tick();
    ld_req = 1'b0; tp_req = 1'b1; tp_addr = 16'hC002;
    @(negedge clk_sys);
    check("tp_grant_addr", ram_addr, 16'hC002);
    check("tp_grant_we", ram_we, 1'b0);
    tick();
    tp_req = 1'b0;
    @(negedge clk_sys);
    check("tp_ack_after_grant", tp_ack, 1'b1);
    check("tp_dout_c002", tp_dout, 8'h33);

    // Continuous CPU access with a waiting loader: hold every MAXWAIT+1 cycles
    repeat (2) tick();
    hold_cnt = 0;
    for (int c = 1; c <= 27; c++) begin
      tick();
      cpu_sel = !cpu_hold; cpu_we = 1'b0; cpu_addr = 16'(c);
      ld_req = 1'b1; ld_addr = 16'hD000 + 16'(c); ld_din = 8'(c);
      @(negedge clk_sys);
      if (cpu_hold) begin
        hold_cnt++;
        check("hold_cycle", c, 9 * hold_cnt);
        check("hold_ld_ack", ld_ack, 1'b1);
      end
    end
    check("hold_count", hold_cnt, 3);
    tick();
    quiet();

    // Loader and tape together: loader first, tape after loader drops
    tp_req = 1'b1; tp_addr = 16'hC001;
    for (int i = 0; i < 3; i++) begin
      ld_req = 1'b1; ld_addr = 16'hE000 + 16'(i); ld_din = 8'hA1;
      @(negedge clk_sys);
      check("ld_over_tp", ld_ack, 1'b1);
      tick();
    end
    ld_req = 1'b0;
    @(negedge clk_sys);
    check("tp_after_ld_en", ram_en, 1'b1);
    check("tp_after_ld_addr", ram_addr, 16'hC001);
    tick();
    tp_req = 1'b0;
    @(negedge clk_sys);
    check("tp_after_ld_ack", tp_ack, 1'b1);
    check("tp_after_ld_data", tp_dout, 8'h22);

    // Reset in the cycle after a tape grant, with a loader write attempted during reset
    tick();
    tick();
    tp_req = 1'b1; tp_addr = 16'hC000;
    @(negedge clk_sys);
    check("rst_tp_grant", ram_addr, 16'hC000);
    tick();
    reset = 1'b1; tp_req = 1'b0; ld_req = 1'b1; ld_addr = 16'hF000; ld_din = 8'h77;
    @(negedge clk_sys);
    check("rst_ram_en", ram_en, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ld_ack", ld_ack, 1'b0);
    tick();
    reset = 1'b0; ld_req = 1'b0;
    @(negedge clk_sys);
    check("rst_tp_ack", tp_ack, 1'b0);
    check("rst_tp_dout", tp_dout, 8'h00);
    check("rst_no_write", ram_mem[16'hF000], 8'h05);

    // Random traffic, checked every cycle by the model
    for (int n = 0; n < 3000; n++) begin
      logic want, viol;
      tick();
      want = ($urandom_range(0, 9) < 6);
      viol = ($urandom_range(0, 31) == 0);
      reset    = ($urandom_range(0, 399) == 0);
      cpu_sel  = want && (!cpu_hold || viol);
      cpu_we   = $urandom_range(0, 1) == 1;
      cpu_addr = 16'h0100 + 16'($urandom_range(0, 31));
      cpu_din  = 8'($urandom);
      ld_req   = ($urandom_range(0, 9) < 4);
      ld_addr  = 16'h0100 + 16'($urandom_range(0, 31));
      ld_din   = 8'($urandom);
      tp_req   = ($urandom_range(0, 1) == 1);
      if (tp_ack || $urandom_range(0, 3) == 0)
        tp_addr = 16'h0100 + 16'($urandom_range(0, 31));
    end
    tick();
    reset = 1'b0;
    quiet();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
